// File: rtl/move_pulse_gen.sv
// Debounced four-way key to one-cycle move-pulse generator for the card-location tracker.
// Optional auto-repeat while a key stays held is compiled in when AUTO_REPEAT_EN is defined.
module move_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic busy
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

    // An out-of-range parameter set fails elaboration on a missing module.
    generate
        if (!CFG_OK) begin : g_cfg_error
            move_pulse_gen_bad_parameters u_bad_cfg ();
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Key order in every 4-bit vector: [0]=up, [1]=down, [2]=left, [3]=right.
    logic [3:0]       key_raw;
    logic [3:0]       key_sync_p0;
    logic [3:0]       key_sync_p1;
    logic [3:0]       sk;
    state_t           state;
    logic [1:0]       dir;
    logic             dir_key;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pulse_q;
    logic             busy_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt;
    logic             rpt_first;
    logic [CNT_W-1:0] rpt_last;

    assign rpt_last = rpt_first ? RPT_FIRST_LAST : RPT_NEXT_LAST;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] pick_dir(input logic [3:0] k);
        if (k[0])      return 2'd0;
        else if (k[1]) return 2'd1;
        else if (k[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign key_raw = {key_right, key_left, key_down, key_up};
    assign sk      = key_sync_p1;
    assign dir_key = sk[dir];

    // Stage p0/p1: two-flop synchronizer on the raw buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_sync_p0 <= '0;
            key_sync_p1 <= '0;
        end else begin
            key_sync_p0 <= key_raw;
            key_sync_p1 <= key_sync_p0;
        end
    end

    // Control FSM; pulses and busy are registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dir     <= '0;
            cnt     <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt       <= '0;
            rpt_first <= 1'b0;
`endif
        end else begin
            pulse_q <= '0;
            case (state)
                IDLE: begin
                    if (|sk) begin
                        dir    <= pick_dir(sk);
                        cnt    <= '0;
                        state  <= DEBOUNCE;
                        busy_q <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!dir_key) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt >= DB_LAST) begin
                        state        <= HELD;
                        pulse_q[dir] <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt       <= '0;
                        rpt_first <= 1'b1;
`endif
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                HELD: begin
                    if (!dir_key) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rpt >= rpt_last) begin
                        pulse_q[dir] <= 1'b1;
                        rpt          <= '0;
                        rpt_first    <= 1'b0;
                    end else begin
                        rpt <= sat_inc(rpt);
                    end
`endif
                end
                RELEASE: begin
                    // A short dip is bounce: resume HELD with the repeat timer untouched.
                    if (dir_key) begin
                        state <= HELD;
                    end else if (cnt >= DB_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign up    = pulse_q[0];
    assign down  = pulse_q[1];
    assign left  = pulse_q[2];
    assign right = pulse_q[3];
    assign busy  = busy_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Randomized and directed bench for move_pulse_gen against a press/hold/release event model.
module tb_move_pulse_gen;

    localparam int DB     = 4;
    localparam int RDELAY = 16;
    localparam int RPER   = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic reset;
    logic key_up, key_down, key_left, key_right;
    logic up, down, left, right, busy;

    move_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_up   (key_up),
        .key_down (key_down),
        .key_left (key_left),
        .key_right(key_right),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    // Reference model: tracks a press as an event with run lengths and a held-time count.
    logic [3:0] m_s1, m_s2;
    bit         m_active, m_acc;
    int         m_dir, m_run, m_low, m_held;
    logic [3:0] m_pulse;
    bit         m_busy;

    int cyc;
    int first_busy, first_pulse;
    int n_pulses [4];

    function automatic bit repeat_due(input int h);
        return AR && ((h == RDELAY) || (h > RDELAY && ((h - RDELAY) % RPER) == 0));
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0;
        m_active = 0; m_acc = 0;
        m_run = 0; m_low = 0; m_held = 0; m_dir = 0;
        m_pulse = '0; m_busy = 0;
    endtask

    task automatic model_step(input logic [3:0] raw);
        logic [3:0] s;
        s = m_s2;
        m_pulse = '0;
        if (!m_active) begin
            if (s != 0) begin
                m_active = 1; m_acc = 0; m_run = 0;
                m_dir = s[0] ? 0 : s[1] ? 1 : s[2] ? 2 : 3;
            end
        end else if (!m_acc) begin
            if (!s[m_dir]) m_active = 0;
            else begin
                m_run++;
                if (m_run == DB) begin
                    m_pulse[m_dir] = 1'b1;
                    m_acc = 1; m_held = 0; m_low = 0;
                end
            end
        end else begin
            if (s[m_dir]) begin
                if (m_low == 0) begin
                    m_held++;
                    if (repeat_due(m_held)) m_pulse[m_dir] = 1'b1;
                end
                m_low = 0;
            end else begin
                m_low++;
                if (m_low == DB + 1) m_active = 0;
            end
        end
        m_busy = m_active;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic clear_stats();
        cyc = 0; first_busy = -1; first_pulse = -1;
        for (int i = 0; i < 4; i++) n_pulses[i] = 0;
    endtask

    task automatic run_cycle(input logic [3:0] k);
        logic [3:0] p;
        {key_right, key_left, key_down, key_up} = k;
        @(posedge clk);
        model_step(k);
        @(negedge clk);
        p = {right, left, down, up};
        check("pulse", 32'(p), 32'(m_pulse));
        check("busy", 32'(busy), 32'(m_busy));
        check("onehot", 32'($countones(p) <= 1), 32'd1);
        for (int i = 0; i < 4; i++) if (p[i]) n_pulses[i]++;
        if (busy && first_busy < 0) first_busy = cyc;
        if (p != 0 && first_pulse < 0) first_pulse = cyc;
        cyc++;
    endtask

    task automatic run_n(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) run_cycle(k);
    endtask

    // Called just after a negedge: reset is pulsed entirely between two rising edges.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_pulse", 32'({right, left, down, up}), 32'd0);
        #1 reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] pat;
        int r, len;
        reset = 1'b0;
        {key_right, key_left, key_down, key_up} = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse", 32'({right, left, down, up}), 32'd0);
        reset = 1'b1;

        // Single up press held 20 cycles
        clear_stats();
        run_n(4'b0001, 20);
        run_n(4'b0000, 12);
        check("up_first_busy", 32'(first_busy), 32'd2);
        check("up_first_pulse", 32'(first_pulse), 32'd6);
        check("up_count", 32'(n_pulses[0]), 32'd1);
        check("up_others", 32'(n_pulses[1] + n_pulses[2] + n_pulses[3]), 32'd0);
        check("up_busy_end", 32'(busy), 32'd0);

        // Right with bounce, final rise at cycle 3
        clear_stats();
        run_n(4'b1000, 2);
        run_n(4'b0000, 1);
        run_n(4'b1000, 15);
        run_n(4'b0000, 12);
        check("bounce_first_pulse", 32'(first_pulse), 32'd9);
        check("bounce_count", 32'(n_pulses[3]), 32'd1);

        // Up and left together: up wins
        clear_stats();
        run_n(4'b0101, 20);
        run_n(4'b0000, 12);
        check("prio_first_pulse", 32'(first_pulse), 32'd6);
        check("prio_up", 32'(n_pulses[0]), 32'd1);
        check("prio_left", 32'(n_pulses[2]), 32'd0);

        // Down with a 2-cycle dip
        clear_stats();
        run_n(4'b0010, 10);
        run_n(4'b0000, 2);
        run_n(4'b0010, 10);
        run_n(4'b0000, 12);
        check("dip_down_count", 32'(n_pulses[1]), 32'd1);
        check("dip_busy_end", 32'(busy), 32'd0);

        // Left held 41 cycles
        clear_stats();
        run_n(4'b0100, 41);
        run_n(4'b0000, 12);
        check("hold_left_count", 32'(n_pulses[2]), AR ? 32'd4 : 32'd1);
        check("hold_first_pulse", 32'(first_pulse), 32'd6);

        // Reset mid-debounce with key still held
        clear_stats();
        run_n(4'b0001, 5);
        async_reset();
        first_pulse = -1;
        run_n(4'b0001, 15);
        run_n(4'b0000, 12);
        check("rstpress_first_pulse", 32'(first_pulse), 32'd11);
        check("rstpress_count", 32'(n_pulses[0]), 32'd1);

        // Randomized segments with occasional asynchronous reset
        pat = 4'b0;
        for (int s = 0; s < 160; s++) begin
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 24);
            case (r)
                0, 1, 2, 3: pat = 4'(1 << r);
                4, 6, 7:    begin pat = 4'b0; if (r != 4) len = $urandom_range(1, 6); end
                5:          pat = 4'($urandom_range(0, 15));
                default:    ;
            endcase
            run_n(pat, len);
            if ($urandom_range(0, 19) == 0) async_reset();
        end
        run_n(4'b0000, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/move_pulse_gen.md
MOVE_PULSE_GEN -- requirements
Module: move_pulse_gen

Interface
REQ-001 DEBOUNCE_CYCLES, 4, stable cycles (>=1) required to accept a press or a release.
REQ-002 REPEAT_DELAY, 16, cycles from first pulse to first auto-repeat pulse (>=1, used only with AUTO_REPEAT_EN).
REQ-003 REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (>=1, used only with AUTO_REPEAT_EN).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 key_up, key_down, key_left, key_right  input  1 each  raw asynchronous active-high buttons.
REQ-007 up, down, left, right  output  1 each  registered one-cycle move pulses for the card-location tracker.
REQ-008 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-009 Each key SHALL pass a 2-flop synchronizer; FSM uses only synchronized values (sk).
REQ-010 FSM states: IDLE, DEBOUNCE, HELD, RELEASE; direction register dir holds the accepted key.
REQ-011 IDLE: any sk high -> latch dir by priority up > down > left > right, clear cnt, go DEBOUNCE.
REQ-012 DEBOUNCE: sk[dir] low -> IDLE, no pulse; sk[dir] high and cnt == DEBOUNCE_CYCLES-1 -> HELD with one pulse on dir; otherwise cnt increments.
REQ-013 Latency: key first sampled high at edge E0 and held stable -> pulse high only in the cycle after edge E0+2+DEBOUNCE_CYCLES.
REQ-014 HELD: sk[dir] low -> RELEASE, cnt cleared; other keys ignored.
REQ-015 RELEASE: sk[dir] high -> HELD, no pulse, repeat timer unchanged; low for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-016 At most one of up/down/left/right SHALL be high in any cycle; each pulse lasts exactly one cycle.
REQ-017 A key held through return to IDLE SHALL be treated as a new press (full debounce before pulse).
REQ-018 Counters SHALL be 16 bits, saturating; no wrap-around.

Reset
REQ-019 reset low SHALL immediately force up/down/left/right/busy to 0, state IDLE, cnt, repeat timer, dir and synchronizer flops to 0.
REQ-020 Reset asserted mid-DEBOUNCE or mid-HELD SHALL drop the pending press; no pulse emitted for it.
REQ-021 After reset deasserts with a key held, behaviour SHALL equal a fresh press with E0 = first edge after deassertion.

Configuration
REQ-022 Macro AUTO_REPEAT_EN defined: in HELD, repeat pulse on dir at REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles while held; RELEASE pauses the timer.
REQ-023 AUTO_REPEAT_EN undefined: exactly one pulse per accepted press; repeat timer logic not compiled.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
REQ-024 key_up high from E0 for 20 cycles, macro off -> single up pulse after E6; busy high E2 through release debounce; nothing else.
REQ-025 key_right high 2 cycles, low 1, then held (final rise at E3) -> single right pulse after E9; no pulse from bounce.
REQ-026 key_up and key_left rise together at E0 -> up pulse only after E6; left never pulses while up held.
REQ-027 key_down held, dropped for 2 cycles, raised again -> no second down pulse; full release > 4 cycles -> IDLE.
REQ-028 AUTO_REPEAT_EN, key_left held E0..E40 -> left pulses after E6, E22, E30, E38 only.
REQ-029 reset low at E4 during key_up press, released before E5, key still held -> outputs 0 asynchronously; single up pulse 6 edges after first post-reset edge.
